// File: rtl/block_field_pkg.sv
// Shared definitions for the breakout block field: geometry, level FSM states,
// the level patterns and the popcount helper.
package block_field_pkg;

  localparam int BLOCKS_PER_ROW = 13;
  localparam int NUM_ROWS       = 1;
  localparam int NUM_BLOCKS     = BLOCKS_PER_ROW * NUM_ROWS;
  localparam int NUM_LEVELS     = 4;
  localparam int IDX_W          = $clog2(NUM_BLOCKS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_PLAY    = 2'd2,
    ST_CLEARED = 2'd3
  } state_t;

  // Pattern kinds: 0 full field, 1 alternating columns from col 0, 2 outer two columns empty.
  function automatic logic [NUM_BLOCKS-1:0] make_pattern(input int kind);
    logic [NUM_BLOCKS-1:0] p;
    p = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < BLOCKS_PER_ROW; c++) begin
        case (kind)
          0:       p[r*BLOCKS_PER_ROW + c] = 1'b1;
          1:       p[r*BLOCKS_PER_ROW + c] = ((c % 2) == 0);
          2:       p[r*BLOCKS_PER_ROW + c] = (c >= 2) && (c < BLOCKS_PER_ROW - 2);
          default: p[r*BLOCKS_PER_ROW + c] = 1'b1;
        endcase
      end
    end
    return p;
  endfunction

  localparam logic [NUM_BLOCKS-1:0] PAT_L0 = make_pattern(0);
  localparam logic [NUM_BLOCKS-1:0] PAT_L1 = make_pattern(1);
  localparam logic [NUM_BLOCKS-1:0] PAT_L2 = make_pattern(2);
  localparam logic [NUM_BLOCKS-1:0] PAT_L3 = make_pattern(0);

  function automatic logic [7:0] popcount(input logic [NUM_BLOCKS-1:0] v);
    logic [7:0] n;
    n = 8'd0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/block_field_ctrl_if.sv
// Hit request/acknowledge channel between the ball/collision logic (master)
// and the block field controller (slave).
interface block_field_ctrl_if;
  logic       hit_req;
  logic [7:0] hit_idx;
  logic       hit_ack;
  logic       hit_present;

  modport master (output hit_req, hit_idx, input hit_ack, hit_present);
  modport slave  (input hit_req, hit_idx, output hit_ack, hit_present);
endinterface

// File: rtl/block_field_ctrl_level_pattern_rom.sv
// Combinational level pattern lookup; also reports how many blocks the pattern holds.
module level_pattern_rom
  import block_field_pkg::*;
(
  input  logic [1:0]            i_level,
  output logic [NUM_BLOCKS-1:0] o_pattern,
  output logic [7:0]            o_count
);

  // Select the block pattern for the requested level.
  always_comb begin
    o_pattern = PAT_L0;
    case (i_level)
      2'd0:    o_pattern = PAT_L0;
      2'd1:    o_pattern = PAT_L1;
      2'd2:    o_pattern = PAT_L2;
      2'd3:    o_pattern = PAT_L3;
      default: o_pattern = PAT_L0;
    endcase
  end

  assign o_count = popcount(o_pattern);

endmodule

// File: rtl/block_field_ctrl.sv
// Breakout block field controller: level FSM, hit handling, score/level tracking
// and the frame-synchronous display copy. Optional armour: BLOCK_FIELD_TWO_HIT_EN.
module block_field_ctrl
  import block_field_pkg::*;
#(
  parameter int SCORE_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  new_frame,
  block_field_ctrl_if.slave     hit_if,
  output logic [NUM_BLOCKS-1:0] block_state,
`ifdef BLOCK_FIELD_TWO_HIT_EN
  output logic [NUM_BLOCKS-1:0] armour_state,
`endif
  output logic [7:0]            blocks_left,
  output logic [SCORE_W-1:0]    score,
  output logic [1:0]            level,
  output logic                  level_clear,
  output logic                  busy
);

  localparam logic [NUM_BLOCKS-1:0] BIT0      = NUM_BLOCKS'(1);
  localparam logic [SCORE_W-1:0]    SCORE_MAX = '1;

  state_t                r_state;
  logic [NUM_BLOCKS-1:0] r_working;
  logic [NUM_BLOCKS-1:0] r_block_state;
  logic [NUM_BLOCKS-1:0] r_ack_mask;
  logic [7:0]            r_blocks_left;
  logic [SCORE_W-1:0]    r_score;
  logic [1:0]            r_level;
  logic                  r_hit_ack;
  logic                  r_hit_present;
  logic                  r_level_clear;
  logic                  r_busy;
`ifdef BLOCK_FIELD_TWO_HIT_EN
  logic [NUM_BLOCKS-1:0] r_armour;
  logic [NUM_BLOCKS-1:0] r_armour_state;
  logic [NUM_BLOCKS-1:0] r_arm_ack_mask;
  logic                  w_armoured;
`endif

  logic [NUM_BLOCKS-1:0] w_rom_pattern;
  logic [7:0]            w_rom_count;
  logic [NUM_BLOCKS-1:0] w_mask;
  logic                  w_accept;
  logic                  w_present;
  logic                  w_remove;
  logic [1:0]            w_score_inc;
  logic [SCORE_W:0]      w_score_sum;
  logic [SCORE_W-1:0]    w_score_next;

  level_pattern_rom u_rom (
    .i_level   (r_level),
    .o_pattern (w_rom_pattern),
    .o_count   (w_rom_count)
  );

  // Decode the requested index and what a hit on it would do to the field.
  always_comb begin
    w_accept = hit_if.hit_req && !r_hit_ack;
    if (hit_if.hit_idx < 8'(NUM_BLOCKS)) begin
      w_mask = BIT0 << hit_if.hit_idx[IDX_W-1:0];
    end else begin
      w_mask = '0;
    end
    if (r_state == ST_PLAY) begin
      w_present = |(r_working & w_mask);
    end else begin
      w_present = 1'b0;
    end
`ifdef BLOCK_FIELD_TWO_HIT_EN
    w_armoured = w_present && |(r_armour & w_mask);
    w_remove   = w_present && !w_armoured;
    if (!w_present) begin
      w_score_inc = 2'd0;
    end else if (w_armoured) begin
      w_score_inc = 2'd1;
    end else begin
      w_score_inc = 2'd2;
    end
`else
    w_remove = w_present;
    if (w_present) begin
      w_score_inc = 2'd1;
    end else begin
      w_score_inc = 2'd0;
    end
`endif
    w_score_sum = {1'b0, r_score} + {{(SCORE_W-1){1'b0}}, w_score_inc};
    if (w_score_sum[SCORE_W]) begin
      w_score_next = SCORE_MAX;
    end else begin
      w_score_next = w_score_sum[SCORE_W-1:0];
    end
  end

  // Level FSM, hit servicing and display synchronisation.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_working     <= '0;
      r_block_state <= '0;
      r_ack_mask    <= '0;
      r_blocks_left <= 8'd0;
      r_score       <= '0;
      r_level       <= 2'd0;
      r_hit_ack     <= 1'b0;
      r_hit_present <= 1'b0;
      r_level_clear <= 1'b0;
      r_busy        <= 1'b0;
`ifdef BLOCK_FIELD_TWO_HIT_EN
      r_armour       <= '0;
      r_armour_state <= '0;
      r_arm_ack_mask <= '0;
`endif
    end else begin
      r_hit_ack     <= w_accept;
      r_hit_present <= w_accept && w_present;
      r_ack_mask    <= (w_accept && w_remove) ? w_mask : '0;
      r_level_clear <= 1'b0;
`ifdef BLOCK_FIELD_TWO_HIT_EN
      r_arm_ack_mask <= (w_accept && w_armoured) ? w_mask : '0;
`endif

      // A frame starting during the ack cycle must still show the block just hit.
      if (new_frame) begin
        r_block_state <= r_working | r_ack_mask;
`ifdef BLOCK_FIELD_TWO_HIT_EN
        r_armour_state <= r_armour | r_arm_ack_mask;
`endif
      end else begin
        r_block_state <= r_block_state;
      end

      if (w_accept && w_present) begin
        r_score <= w_score_next;
`ifdef BLOCK_FIELD_TWO_HIT_EN
        if (w_armoured) begin
          r_armour <= r_armour & ~w_mask;
        end else begin
          r_working     <= r_working & ~w_mask;
          r_blocks_left <= r_blocks_left - 8'd1;
        end
`else
        r_working     <= r_working & ~w_mask;
        r_blocks_left <= r_blocks_left - 8'd1;
`endif
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_score <= '0;
            r_level <= 2'd0;
            r_busy  <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_working     <= w_rom_pattern;
          r_blocks_left <= w_rom_count;
`ifdef BLOCK_FIELD_TWO_HIT_EN
          r_armour <= r_level[0] ? '0 : w_rom_pattern;
`endif
          r_state <= ST_PLAY;
          r_busy  <= 1'b0;
        end
        ST_PLAY: begin
          if (r_blocks_left == 8'd0) begin
            r_state <= ST_CLEARED;
            r_busy  <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        ST_CLEARED: begin
          if (new_frame) begin
            r_level_clear <= 1'b1;
            r_level       <= 2'((32'(r_level) + 1) % NUM_LEVELS);
            r_state       <= ST_LOAD;
          end else begin
            r_state <= ST_CLEARED;
          end
          r_busy <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign hit_if.hit_ack     = r_hit_ack;
  assign hit_if.hit_present = r_hit_present;
  assign block_state        = r_block_state;
  assign blocks_left        = r_blocks_left;
  assign score              = r_score;
  assign level              = r_level;
  assign level_clear        = r_level_clear;
  assign busy               = r_busy;
`ifdef BLOCK_FIELD_TWO_HIT_EN
  assign armour_state       = r_armour_state;
`endif

endmodule

// File: tb/tb_block_field_ctrl.sv
// Self-checking bench for block_field_ctrl: directed steps plus randomized level
// play checked against a transaction-level model of the block field.
module tb_block_field_ctrl;

  localparam int NB    = 13;
  localparam int SMAX  = 1023;

  logic clk = 1'b0;
  logic rst, start, new_frame;
  logic [NB-1:0] block_state;
  logic [7:0]    blocks_left;
  logic [9:0]    score;
  logic [1:0]    level;
  logic          level_clear, busy;
`ifdef BLOCK_FIELD_TWO_HIT_EN
  logic [NB-1:0] armour_state;
`endif

  block_field_ctrl_if hif ();

  block_field_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .new_frame   (new_frame),
    .hit_if      (hif),
    .block_state (block_state),
`ifdef BLOCK_FIELD_TWO_HIT_EN
    .armour_state(armour_state),
`endif
    .blocks_left (blocks_left),
    .score       (score),
    .level       (level),
    .level_clear (level_clear),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  logic [NB-1:0] m_blocks;
  logic [NB-1:0] m_display;
  int            m_score;
  int            m_level;
  bit            m_playing;

  function automatic logic [NB-1:0] pattern_of(input int lvl);
    logic [NB-1:0] p;
    for (int c = 0; c < NB; c++) begin
      if (lvl == 1)      p[c] = (c % 2 == 0);
      else if (lvl == 2) p[c] = (c >= 2 && c <= 10);
      else               p[c] = 1'b1;
    end
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    m_display = m_blocks;
    check("frame_disp", 32'(block_state), 32'(m_display));
  endtask

  task automatic do_hit(input int idx, input logic nf);
    logic exp_p;
    exp_p = 1'b0;
    if (m_playing && idx < NB) exp_p = m_blocks[idx];
    hif.hit_req = 1'b1;
    hif.hit_idx = 8'(idx);
    new_frame   = nf;
    tick();
    if (nf) begin
      m_display = m_blocks;
      check("hit_frame_disp", 32'(block_state), 32'(m_display));
    end
    if (exp_p) begin
      m_blocks[idx] = 1'b0;
      m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
    end
    check("hit_ack", 32'(hif.hit_ack), 32'd1);
    check("hit_present", 32'(hif.hit_present), 32'(exp_p));
    check("score", 32'(score), 32'(m_score));
    check("blocks_left", 32'(blocks_left), 32'($countones(m_blocks)));
    hif.hit_req = 1'b0;
    new_frame   = 1'b0;
    tick();
    check("ack_single", 32'(hif.hit_ack), 32'd0);
  endtask

  // Remove every remaining block in random order with occasional stray hits and frames.
  task automatic play_level(input int junk_div);
    int order[$];
    int j, t;
    for (int i = 0; i < NB; i++) if (m_blocks[i]) order.push_back(i);
    for (int i = order.size() - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    foreach (order[k]) begin
      if ($urandom_range(junk_div - 1, 0) == 0) do_hit($urandom_range(255, 0), 1'b0);
      if ($urandom_range(7, 0) == 0) frame();
      do_hit(order[k], ($urandom_range(7, 0) == 0));
    end
  endtask

  // After the last removal: CLEARED, then level advance, LOAD and first frame.
  task automatic finish_level();
    check("cleared_busy", 32'(busy), 32'd1);
    m_playing = 1'b0;
    do_hit($urandom_range(12, 0), 1'b0);
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    m_level   = (m_level + 1) % 4;
    m_display = m_blocks;
    check("level_clear_pulse", 32'(level_clear), 32'd1);
    check("level_next", 32'(level), 32'(m_level));
    check("busy_load", 32'(busy), 32'd1);
    check("disp_cleared", 32'(block_state), 32'(m_display));
    tick();
    m_blocks  = pattern_of(m_level);
    m_playing = 1'b1;
    check("level_clear_low", 32'(level_clear), 32'd0);
    check("busy_play", 32'(busy), 32'd0);
    check("load_left", 32'(blocks_left), 32'($countones(m_blocks)));
    frame();
  endtask

  task automatic check_reset_outputs();
    check("rst_disp", 32'(block_state), 32'd0);
    check("rst_left", 32'(blocks_left), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ack", 32'(hif.hit_ack), 32'd0);
    check("rst_present", 32'(hif.hit_present), 32'd0);
    check("rst_lclear", 32'(level_clear), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_score = 0; m_level = 0;
    check("start_busy", 32'(busy), 32'd1);
    tick();
    m_blocks  = pattern_of(0);
    m_playing = 1'b1;
    check("start_busy_1cyc", 32'(busy), 32'd0);
    check("start_left", 32'(blocks_left), 32'(NB));
    check("disp_before_frame", 32'(block_state), 32'd0);
    check("start_level", 32'(level), 32'd0);
  endtask

  initial begin
    int rounds;
    rst = 1'b1; start = 1'b0; new_frame = 1'b0;
    hif.hit_req = 1'b0; hif.hit_idx = 8'd0;
    m_blocks = '0; m_display = '0; m_score = 0; m_level = 0; m_playing = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs();

    // hit while idle: acked, nothing there
    do_hit(3, 1'b0);

    start_game();
    frame();
    check("first_frame_full", 32'(block_state), 32'h1FFF);

    // removal shows only after the next frame
    do_hit(4, 1'b0);
    check("bit4_still_shown", 32'(block_state[4]), 32'd1);
    frame();
    check("bit4_cleared", 32'(block_state[4]), 32'd0);

    do_hit(4, 1'b0);
    do_hit(13, 1'b0);

    // held request: acks two cycles apart
    hif.hit_req = 1'b1; hif.hit_idx = 8'd13;
    tick(); check("held_ack1", 32'(hif.hit_ack), 32'd1);
    tick(); check("held_gap", 32'(hif.hit_ack), 32'd0);
    tick(); check("held_ack2", 32'(hif.hit_ack), 32'd1);
    check("held_present", 32'(hif.hit_present), 32'd0);
    hif.hit_req = 1'b0;
    tick();

    // start outside IDLE is ignored
    start = 1'b1; tick(); start = 1'b0;
    check("start_ignored_busy", 32'(busy), 32'd0);
    check("start_ignored_score", 32'(score), 32'(m_score));

    // hit coinciding with a frame: that frame still shows the block
    do_hit(7, 1'b1);
    check("coinc_bit7_shown", 32'(block_state[7]), 32'd1);
    frame();
    check("coinc_bit7_gone", 32'(block_state[7]), 32'd0);

    play_level(6);
    finish_level();
    check("level1_disp", 32'(block_state), 32'h1555);

    // many levels until the score saturates, then one more level
    rounds = 0;
    while ((m_score < SMAX || rounds < 200) && rounds < 200) begin
      play_level(16);
      finish_level();
      rounds = (m_score >= SMAX) ? 200 : rounds + 1;
    end
    play_level(16);
    check("score_saturated", 32'(score), 32'(SMAX));
    finish_level();

    // reset mid-play with a request held: no ack, everything back to reset
    do_hit(5, 1'b0);
    hif.hit_req = 1'b1; hif.hit_idx = 8'd0;
    rst = 1'b1;
    tick(); check("rst_noack1", 32'(hif.hit_ack), 32'd0);
    tick(); check("rst_noack2", 32'(hif.hit_ack), 32'd0);
    hif.hit_req = 1'b0;
    tick();
    rst = 1'b0;
    m_blocks = '0; m_playing = 1'b0; m_score = 0; m_level = 0;
    check_reset_outputs();
    tick();
    check("post_rst_ack", 32'(hif.hit_ack), 32'd0);
    start_game();
    frame();
    do_hit(12, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
